// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller.
//   state_e    : controller state encoding (OFF, SHIFT, FLASH)
//   COLOR_*    : one-hot colour codes driven on o_color, bit order {blue, green, red}
//   BTN_*      : bit positions of the push-buttons in i_btn
//   SW_*       : bit positions of the single-bit switches in i_sw
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLASH = 2'd2
  } state_e;

  localparam logic [2:0] COLOR_RED   = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b100;

  localparam int BTN_MODE  = 0;
  localparam int BTN_RED   = 1;
  localparam int BTN_GREEN = 2;
  localparam int BTN_BLUE  = 3;

  localparam int SW_EN  = 0;
  localparam int SW_DIR = 3;

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// One-bit button conditioner: 2-flop synchroniser, debounce filter and
// press-event pulse.
//   clock    : system clock
//   ck_rst   : asynchronous active-low reset
//   i_btn    : raw, asynchronous button level
//   o_press  : one-cycle pulse in the cycle after the debounced level rises
// After reset the filter stays disarmed until the button has been seen low
// for DB_CYCLES samples, so a button held through reset never fires.
module btn_debounce #(
  parameter int DB_CYCLES = 8
) (
  input  logic clock,
  input  logic ck_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ref_lvl;

  // NOTE: every variable gets a default before the branches so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    // While disarmed the filter looks for a stable low instead of a change.
    ref_lvl = armed_q ? level_q : 1'b1;
    if (sync2_q == ref_lvl) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (armed_q) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        armed_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern controller: debounced buttons select mode and colour, switches
// enable the pattern and set its step rate.
//   clock    : system clock
//   ck_rst   : asynchronous active-low reset
//   i_btn    : raw buttons [0] mode toggle, [1] red, [2] green, [3] blue
//   i_sw     : switches [0] enable, [2:1] speed select, [3] direction
//   o_step   : one-cycle pulse advancing the LED pattern
//   o_mode   : 0 shift, 1 flash
//   o_color  : one-hot colour {blue, green, red}
//   o_dir    : registered direction switch
//   o_active : controller is not OFF
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int NB_SEL    = 2,
  parameter int NB_COUNT  = 14,
  parameter int DB_CYCLES = 8
) (
  input  logic             clock,
  input  logic             ck_rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [3:0]       i_sw,
  output logic             o_step,
  output logic             o_mode,
  output logic [2:0]       o_color,
  output logic             o_dir,
  output logic             o_active
);

  logic [N_BTN-1:0]    press;
  logic [3:0]          sw_q;
  state_e              state_q, state_d;
  logic [NB_COUNT-1:0] cnt_q, cnt_d, limit;
  logic                step_q, step_d;
  logic                mode_q, mode_d;
  logic                active_q, active_d;
  logic [2:0]          color_q, color_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock   (clock),
      .ck_rst  (ck_rst),
      .i_btn   (i_btn[g]),
      .o_press (press[g])
    );
  end

  // Faster speeds shorten the step period by halving the wrap point.
  assign limit = {NB_COUNT{1'b1}} >> sw_q[NB_SEL:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    color_d = color_q;

    if (press[BTN_RED])        color_d = COLOR_RED;
    else if (press[BTN_GREEN]) color_d = COLOR_GREEN;
    else if (press[BTN_BLUE])  color_d = COLOR_BLUE;

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (sw_q[SW_EN]) state_d = ST_SHIFT;
      end
      ST_SHIFT, ST_FLASH: begin
        if (!sw_q[SW_EN]) begin
          // Disable wins over a mode press arriving in the same cycle.
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (press[BTN_MODE]) begin
          state_d = (state_q == ST_SHIFT) ? ST_FLASH : ST_SHIFT;
          cnt_d   = '0;
        end else if (cnt_q > limit) begin
          // Speed just went up past the current count: restart silently.
          cnt_d = '0;
        end else if (cnt_q == limit) begin
          step_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    mode_d   = (state_d == ST_FLASH);
    active_d = (state_d != ST_OFF);
  end

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sw_q     <= '0;
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
      color_q  <= COLOR_RED;
    end else begin
      sw_q     <= i_sw;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      color_q  <= color_d;
    end
  end

  assign o_step   = step_q;
  assign o_mode   = mode_q;
  assign o_color  = color_q;
  assign o_dir    = sw_q[SW_DIR];
  assign o_active = active_q;

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter N_BTN, default 4, number of push-buttons handled.
REQ-002 Parameter NB_SEL, default 2, width of the speed-select field.
REQ-003 Parameter NB_COUNT, default 14, width of the step prescaler counter.
REQ-004 Parameter DB_CYCLES, default 8, number of consecutive stable samples required to accept a button level.
REQ-005 Port clock  input  1  single system clock; all state on its rising edge.
REQ-006 Port ck_rst  input  1  reset, asynchronous, active-low.
REQ-007 Port i_btn  input  N_BTN  raw buttons: [0] mode toggle, [1] red, [2] green, [3] blue.
REQ-008 Port i_sw  input  4  switches: [0] enable, [2:1] speed select, [3] direction.
REQ-009 Port o_step  output  1  one-cycle pulse advancing the LED pattern.
REQ-010 Port o_mode  output  1  pattern mode: 0 shift, 1 flash.
REQ-011 Port o_color  output  3  one-hot colour {blue, green, red}.
REQ-012 Port o_dir  output  1  registered copy of i_sw[3].
REQ-013 Port o_active  output  1  high when the state machine is not OFF.

Function
REQ-014 Each i_btn bit SHALL pass through a 2-flop synchroniser, then a debouncer that updates its level only after DB_CYCLES consecutive identical synchronised samples.
REQ-015 A press event SHALL be a one-cycle pulse on the cycle after a debounced level rises; release SHALL produce no event.
REQ-016 FSM states SHALL be OFF, SHIFT, FLASH; o_mode SHALL be 1 only in FLASH.
REQ-017 OFF -> SHIFT when registered i_sw[0]=1; SHIFT <-> FLASH on each mode event; SHIFT or FLASH -> OFF when registered i_sw[0]=0.
REQ-018 Disable SHALL take priority over a simultaneous mode event.
REQ-019 A colour event SHALL load o_color one-hot on the next edge; simultaneous colour events SHALL resolve red > green > blue.
REQ-020 A colour event SHALL be accepted in every state, including OFF; o_color SHALL be held otherwise.
REQ-021 The prescaler SHALL count 0..LIMIT and wrap to 0, with LIMIT = (2^NB_COUNT - 1) >> i_sw[2:1].
REQ-022 o_step SHALL pulse for one cycle on the cycle the counter equals LIMIT, only while in SHIFT or FLASH.
REQ-023 In OFF the counter SHALL be held at 0; entering SHIFT SHALL start counting from 0.
REQ-024 A speed change that lowers LIMIT below the current count SHALL force the counter to 0 on the next edge without emitting o_step.
REQ-025 A mode event SHALL clear the counter to 0 on the same edge the mode changes.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-027 While ck_rst=0: state OFF, counter 0, debounced levels 0, o_step 0, o_mode 0, o_color 3'b001, o_dir 0, o_active 0.
REQ-028 Reset asserted mid-operation SHALL take effect immediately; no event SHALL be generated by buttons held through reset release until they are released and pressed again.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (OFF=2'd0, SHIFT=2'd1, FLASH=2'd2), colour one-hot constants, and the button index constants.
REQ-030 One sub-module btn_debounce (synchroniser + debounce counter + rise-event pulse, one bit) SHALL be instantiated N_BTN times.

Verification (DB_CYCLES=4, NB_COUNT=6)
REQ-031 Release reset, i_sw=4'b0001 -> o_active=1 within 3 cycles; o_step every 64 cycles; o_mode=0; o_color=3'b001.
REQ-032 i_btn[0] pulsed high 2 cycles -> no mode change; held 10 cycles -> exactly one toggle to FLASH, counter restarts at 0.
REQ-033 i_btn[2] and i_btn[3] pressed together -> o_color=3'b010; then i_btn[1] and i_btn[3] together -> o_color=3'b001.
REQ-034 Counter at 40 with sel=0, switch sel to 2 (LIMIT 15) -> counter 0 next edge, no o_step; next o_step 16 cycles later.
REQ-035 Mode event and i_sw[0] falling on the same cycle -> state OFF, o_mode=0, no further o_step.
REQ-036 ck_rst asserted in FLASH with i_btn[0] held -> all outputs at reset values immediately; after release, no toggle until button released and re-pressed.
